// File: rtl/uart_dma_host.sv
// uart_dma_host: byte-level initiator for the UART DMA command protocol.
// Builds a command frame (opcode, address, length, payload), streams it to a
// uart_tx over a valid/ready byte interface, then collects response bytes
// from a uart_rx. Payload bytes are fetched from a byte-addressed source
// memory with one cycle of read latency.
module uart_dma_host #(
  parameter int unsigned RX_TIMEOUT  = 2_000_000,
  parameter int unsigned CHUNK_BYTES = 32
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_cmd,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_len,

  output logic        src_rd_en,
  output logic [15:0] src_rd_addr,
  input  logic [7:0]  src_rd_data,

  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,

  input  logic [7:0]  rx_data,
  input  logic        rx_valid,

  output logic [7:0]  rsp_data,
  output logic        rsp_valid,
  output logic        rsp_last,
  output logic [7:0]  status_byte,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  stray_count
);

  localparam int unsigned TmoW      = $clog2(RX_TIMEOUT + 1);
  localparam logic [16:0] ChunkMask = 17'(CHUNK_BYTES - 1);
  localparam logic [16:0] ChunkSize = 17'(CHUNK_BYTES);

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StFetch,
    StData,
    StRecv,
    StDone,
    StErr
  } state_e;

  state_e state_q, state_d;

  logic [7:0]      cmd_q, cmd_d;
  logic [15:0]     addr_q, addr_d;
  logic [15:0]     len_q, len_d;
  logic [2:0]      hdr_idx_q, hdr_idx_d;
  logic [16:0]     pay_idx_q, pay_idx_d;
  logic [16:0]     pay_len_q, pay_len_d;
  logic [16:0]     rsp_len_q, rsp_len_d;
  logic [16:0]     rsp_cnt_q, rsp_cnt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [7:0]      data_q, data_d;
  logic            loaded_q, loaded_d;
  logic [7:0]      rsp_data_q, rsp_data_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_last_q, rsp_last_d;
  logic [7:0]      status_q, status_d;
  logic [7:0]      stray_q, stray_d;
  logic            ready_q, ready_d;

  logic            req_accept;
  logic            req_legal;
  logic [16:0]     req_pay_len;
  logic [16:0]     req_rsp_len;
  logic [16:0]     rsp_round;
  logic [2:0]      hdr_last;
  logic [7:0]      hdr_byte;
  state_e          after_pay;

  // Decode an incoming request into its payload and response sizes.
  always_comb begin
    req_legal   = (req_cmd >= 8'h01) && (req_cmd <= 8'h06);
    req_pay_len = 17'd0;
    req_rsp_len = 17'd0;
    // Round len up to a whole chunk in 17 bits; zero still reads one chunk.
    rsp_round   = ({1'b0, req_len} + ChunkMask) & ~ChunkMask;
    case (req_cmd)
      8'h01, 8'h02: req_pay_len = {1'b0, req_len};
      8'h03:        req_pay_len = 17'd4;
      8'h04:        req_rsp_len = (rsp_round == 17'd0) ? ChunkSize : rsp_round;
      8'h06:        req_rsp_len = 17'd1;
      default: ;
    endcase
  end

  // Header length and the byte currently addressed by the header index.
  always_comb begin
    case (cmd_q)
      8'h01, 8'h02, 8'h04: hdr_last = 3'd4;
      8'h03:               hdr_last = 3'd2;
      default:             hdr_last = 3'd0;
    endcase
    case (hdr_idx_q)
      3'd0:    hdr_byte = cmd_q;
      3'd1:    hdr_byte = addr_q[15:8];
      3'd2:    hdr_byte = addr_q[7:0];
      3'd3:    hdr_byte = len_q[15:8];
      3'd4:    hdr_byte = len_q[7:0];
      default: hdr_byte = 8'h00;
    endcase
    after_pay = (rsp_len_q != 17'd0) ? StRecv : StDone;
  end

  assign req_accept = req_valid && ready_q;

  // Next-state and output logic for the frame sequencer.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    len_d       = len_q;
    hdr_idx_d   = hdr_idx_q;
    pay_idx_d   = pay_idx_q;
    pay_len_d   = pay_len_q;
    rsp_len_d   = rsp_len_q;
    rsp_cnt_d   = rsp_cnt_q;
    tmo_d       = '0;
    data_d      = data_q;
    loaded_d    = loaded_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    rsp_last_d  = 1'b0;
    status_d    = status_q;
    stray_d     = stray_q;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    src_rd_en   = 1'b0;
    src_rd_addr = 16'h0000;

    // Bytes arriving outside a response window are dropped but counted.
    if (rx_valid && (state_q != StRecv) && (stray_q != 8'hFF)) begin
      stray_d = stray_q + 8'd1;
    end

    case (state_q)
      StIdle: begin
        if (req_accept) begin
          cmd_d     = req_cmd;
          addr_d    = req_addr;
          len_d     = req_len;
          hdr_idx_d = 3'd0;
          pay_idx_d = 17'd0;
          rsp_cnt_d = 17'd0;
          pay_len_d = req_pay_len;
          rsp_len_d = req_rsp_len;
          state_d   = req_legal ? StHdr : StErr;
        end
      end

      StHdr: begin
        tx_valid = 1'b1;
        tx_data  = hdr_byte;
        if (tx_ready) begin
          if (hdr_idx_q == hdr_last) begin
            state_d = (pay_len_q != 17'd0) ? StFetch : after_pay;
          end else begin
            hdr_idx_d = hdr_idx_q + 3'd1;
          end
        end
      end

      StFetch: begin
        src_rd_en   = 1'b1;
        src_rd_addr = pay_idx_q[15:0];
        loaded_d    = 1'b0;
        state_d     = StData;
      end

      StData: begin
        // First cycle captures the memory byte; offer it from the register
        // afterwards so tx_data cannot move under backpressure.
        if (!loaded_q) begin
          data_d   = src_rd_data;
          loaded_d = 1'b1;
        end else begin
          tx_valid = 1'b1;
          tx_data  = data_q;
          if (tx_ready) begin
            pay_idx_d = pay_idx_q + 17'd1;
            state_d   = ((pay_idx_q + 17'd1) < pay_len_q) ? StFetch : after_pay;
          end
        end
      end

      StRecv: begin
        if (rx_valid) begin
          rsp_data_d  = rx_data;
          rsp_valid_d = 1'b1;
          rsp_cnt_d   = rsp_cnt_q + 17'd1;
          if (cmd_q == 8'h06) begin
            status_d = rx_data;
          end
          if ((rsp_cnt_q + 17'd1) == rsp_len_q) begin
            rsp_last_d = 1'b1;
            state_d    = StDone;
          end
        end else if (tmo_q == TmoW'(RX_TIMEOUT - 1)) begin
          state_d = StErr;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end

      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    ready_d = (state_d == StIdle);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cmd_q       <= 8'h00;
      addr_q      <= 16'h0000;
      len_q       <= 16'h0000;
      hdr_idx_q   <= 3'd0;
      pay_idx_q   <= 17'd0;
      pay_len_q   <= 17'd0;
      rsp_len_q   <= 17'd0;
      rsp_cnt_q   <= 17'd0;
      tmo_q       <= '0;
      data_q      <= 8'h00;
      loaded_q    <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      status_q    <= 8'h00;
      stray_q     <= 8'h00;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      hdr_idx_q   <= hdr_idx_d;
      pay_idx_q   <= pay_idx_d;
      pay_len_q   <= pay_len_d;
      rsp_len_q   <= rsp_len_d;
      rsp_cnt_q   <= rsp_cnt_d;
      tmo_q       <= tmo_d;
      data_q      <= data_d;
      loaded_q    <= loaded_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      status_q    <= status_d;
      stray_q     <= stray_d;
      ready_q     <= ready_d;
    end
  end

  // req_ready is registered so it stays low while reset is asserted.
  assign req_ready   = ready_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_last    = rsp_last_q;
  assign status_byte = status_q;
  assign stray_count = stray_q;
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign error       = (state_q == StErr);

endmodule

// File: tb/tb_uart_dma_host.sv
// Self-checking bench for uart_dma_host: random transactions compared against a
// frame/response model built directly from the protocol rules.
module tb_uart_dma_host;

  localparam int unsigned RxTimeout = 300;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_cmd;
  logic [15:0] req_addr;
  logic [15:0] req_len;
  logic        src_rd_en;
  logic [15:0] src_rd_addr;
  logic [7:0]  src_rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  rsp_data;
  logic        rsp_valid;
  logic        rsp_last;
  logic [7:0]  status_byte;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  stray_count;

  uart_dma_host #(
    .RX_TIMEOUT (RxTimeout),
    .CHUNK_BYTES(32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cmd    (req_cmd),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .src_rd_en  (src_rd_en),
    .src_rd_addr(src_rd_addr),
    .src_rd_data(src_rd_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rsp_data   (rsp_data),
    .rsp_valid  (rsp_valid),
    .rsp_last   (rsp_last),
    .status_byte(status_byte),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .stray_count(stray_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] src_mem [256];
  logic [7:0] tx_log[$];
  logic [7:0] exp_tx[$];
  logic [7:0] rsp_log[$];
  logic [7:0] rx_sent[$];
  bit         last_log[$];
  int         addr_log[$];
  int         done_cnt, err_cnt, stab_err, busy_err;
  int         cyc = 0;
  int         err_cyc, last_rx_cyc;
  int         bp_mode = 0;
  bit         acc_next = 0;
  bit         rd_pend = 0;
  logic [7:0] rd_addr;
  bit         hold_chk = 0;
  logic [7:0] hold_data;
  bit         prev_done = 0;

  // Monitor: sample everything on the falling edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      hold_chk  = 0;
      prev_done = 0;
      acc_next  = 0;
      rd_pend   = 0;
    end else begin
      acc_next = tx_valid && tx_ready;
      if (tx_valid && tx_ready) tx_log.push_back(tx_data);
      if (hold_chk && (!tx_valid || tx_data !== hold_data)) stab_err++;
      hold_chk  = tx_valid && !tx_ready;
      hold_data = tx_data;
      if (src_rd_en) begin
        addr_log.push_back(int'(src_rd_addr));
        rd_pend = 1;
        rd_addr = src_rd_addr[7:0];
      end
      if (rsp_valid) begin
        rsp_log.push_back(rsp_data);
        last_log.push_back(rsp_last);
      end
      if (done) begin
        done_cnt++;
        if (!busy) busy_err++;
      end
      if (prev_done && busy) busy_err++;
      prev_done = done;
      if (error) begin
        err_cnt++;
        err_cyc = cyc;
      end
    end
  end

  // Source memory (1-cycle latency) and uart_tx readiness model.
  int hold = 0;
  always @(posedge clk) begin
    #1;
    if (rd_pend) begin
      src_rd_data = src_mem[rd_addr];
      rd_pend     = 0;
    end
    case (bp_mode)
      1: begin
        if (acc_next) hold = 5;
        if (hold > 0) begin
          tx_ready = 1'b0;
          hold--;
        end else begin
          tx_ready = 1'b1;
        end
      end
      2:       tx_ready = 1'($urandom_range(0, 1));
      default: tx_ready = 1'b1;
    endcase
  end

  function automatic int rsp_len_of(input logic [7:0] cmd, input logic [15:0] len);
    if (cmd == 8'h04) return (len == 0) ? 32 : ((int'(len) + 31) / 32) * 32;
    if (cmd == 8'h06) return 1;
    return 0;
  endfunction

  task automatic clear_logs();
    tx_log.delete();
    rsp_log.delete();
    last_log.delete();
    addr_log.delete();
    rx_sent.delete();
    done_cnt = 0;
    err_cnt  = 0;
    stab_err = 0;
    busy_err = 0;
  endtask

  task automatic do_req(input logic [7:0] cmd, input logic [15:0] addr,
                        input logic [15:0] len, output bit ok);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_wait: req_ready=%b required 1", req_ready);
      ok = 0;
      return;
    end
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_addr  = addr;
    req_len   = len;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_cmd   = $urandom;
    req_addr  = $urandom;
    req_len   = $urandom;
    ok = 1;
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_valid    = 1'b1;
    rx_data     = b;
    last_rx_cyc = cyc;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = $urandom;
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  // One complete transaction; n_rx below the expected response size forces a timeout.
  task automatic run_txn(input logic [7:0] cmd, input logic [15:0] addr,
                         input logic [15:0] len, input int mode, input int n_rx,
                         input string name);
    int  exp_rsp, pay, n, n_last, bad_idx;
    bit  ok, complete, last_ok;
    logic [7:0] b;
    bp_mode = mode;
    exp_tx.delete();
    exp_tx.push_back(cmd);
    if (cmd == 8'h01 || cmd == 8'h02 || cmd == 8'h04) begin
      exp_tx.push_back(addr[15:8]);
      exp_tx.push_back(addr[7:0]);
      exp_tx.push_back(len[15:8]);
      exp_tx.push_back(len[7:0]);
    end else if (cmd == 8'h03) begin
      exp_tx.push_back(addr[15:8]);
      exp_tx.push_back(addr[7:0]);
    end
    pay = (cmd == 8'h01 || cmd == 8'h02) ? int'(len) : (cmd == 8'h03) ? 4 : 0;
    for (int i = 0; i < pay; i++) exp_tx.push_back(src_mem[i % 256]);
    exp_rsp  = rsp_len_of(cmd, len);
    complete = (n_rx == exp_rsp);
    clear_logs();
    do_req(cmd, addr, len, ok);
    if (!ok) return;

    if (n_rx > 0) begin
      n = 0;
      while (tx_log.size() < exp_tx.size() && n < 20000) begin
        @(negedge clk);
        n++;
      end
      for (int i = 0; i < n_rx; i++) begin
        b = 8'($urandom);
        rx_sent.push_back(b);
        send_rx(b);
      end
    end

    n = 0;
    while (done_cnt + err_cnt == 0 && n < int'(RxTimeout) + 20000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);

    checks++;
    if (done_cnt != (complete ? 1 : 0) || err_cnt != (complete ? 0 : 1)) begin
      errors++;
      $display("FAIL %s_end: done_cnt=%0d err_cnt=%0d required %0d/%0d", name,
               done_cnt, err_cnt, complete ? 1 : 0, complete ? 0 : 1);
    end
    checks++;
    bad_idx = -1;
    for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
      if (bad_idx < 0 && tx_log[i] !== exp_tx[i]) bad_idx = i;
    if (tx_log.size() != exp_tx.size() || bad_idx >= 0) begin
      errors++;
      $display("FAIL %s_tx: got %0d bytes required %0d, first bad index %0d (%h vs %h)",
               name, tx_log.size(), exp_tx.size(), bad_idx,
               (bad_idx >= 0) ? tx_log[bad_idx] : 8'h00,
               (bad_idx >= 0) ? exp_tx[bad_idx] : 8'h00);
    end
    checks++;
    ok = (addr_log.size() == pay);
    for (int i = 0; i < addr_log.size(); i++) if (addr_log[i] != i) ok = 0;
    if (!ok) begin
      errors++;
      $display("FAIL %s_src_addr: %0d fetches required %0d in order 0..", name,
               addr_log.size(), pay);
    end
    checks++;
    if (stab_err != 0) begin
      errors++;
      $display("FAIL %s_tx_hold: %0d unstable cycles required 0", name, stab_err);
    end
    checks++;
    ok = (rsp_log.size() == rx_sent.size());
    for (int i = 0; ok && i < rsp_log.size(); i++) if (rsp_log[i] !== rx_sent[i]) ok = 0;
    if (!ok) begin
      errors++;
      $display("FAIL %s_rsp: got %0d bytes required %0d matching rx", name,
               rsp_log.size(), rx_sent.size());
    end
    checks++;
    n_last = 0;
    foreach (last_log[i]) if (last_log[i]) n_last++;
    last_ok = (n_last == ((complete && exp_rsp > 0) ? 1 : 0));
    if (complete && exp_rsp > 0 && last_log.size() > 0 && !last_log[last_log.size() - 1])
      last_ok = 0;
    if (!last_ok) begin
      errors++;
      $display("FAIL %s_rsp_last: %0d last flags required %0d on final byte", name,
               n_last, (complete && exp_rsp > 0) ? 1 : 0);
    end
    checks++;
    if (busy_err != 0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_idle: busy_err=%0d busy=%b req_ready=%b required 0/0/1", name,
               busy_err, busy, req_ready);
    end
    if (cmd == 8'h06 && complete) begin
      checks++;
      if (status_byte !== rx_sent[0]) begin
        errors++;
        $display("FAIL %s_status: status_byte=%h required %h", name, status_byte,
                 rx_sent[0]);
      end
    end
    if (!complete && n_rx > 0) begin
      checks++;
      if (err_cyc - last_rx_cyc < int'(RxTimeout) + 1 ||
          err_cyc - last_rx_cyc > int'(RxTimeout) + 3) begin
        errors++;
        $display("FAIL %s_timeout_delay: %0d cycles required about %0d", name,
                 err_cyc - last_rx_cyc, RxTimeout + 2);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        error !== 1'b0 || rsp_valid !== 1'b0 || src_rd_en !== 1'b0 ||
        stray_count !== 8'h00 || status_byte !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b txv=%b busy=%b done=%b err=%b stray=%h required 0",
               req_ready, tx_valid, busy, done, error, stray_count);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: req_ready=%b busy=%b required 1/0", req_ready, busy);
    end
  endtask

  task automatic test_write_ub();
    src_mem[0] = 8'hAA;
    src_mem[1] = 8'hBB;
    src_mem[2] = 8'hCC;
    run_txn(8'h01, 16'h0012, 16'd3, 0, 0, "write_ub");
  endtask

  task automatic test_write_instr_bp();
    src_mem[0] = 8'hDE;
    src_mem[1] = 8'hAD;
    src_mem[2] = 8'hBE;
    src_mem[3] = 8'hEF;
    run_txn(8'h03, 16'h0007, 16'd0, 1, 0, "write_instr_bp");
  endtask

  task automatic test_read_ub();
    run_txn(8'h04, 16'h0000, 16'd40, 0, 64, "read_ub_40");
    run_txn(8'h04, 16'($urandom), 16'd0, 2, 32, "read_ub_0");
    run_txn(8'h04, 16'($urandom), 16'd32, 0, 32, "read_ub_32");
    run_txn(8'h04, 16'($urandom), 16'd33, 2, 64, "read_ub_33");
  endtask

  task automatic test_status();
    logic [7:0] b;
    bit ok;
    bp_mode = 0;
    clear_logs();
    do_req(8'h06, 16'($urandom), 16'($urandom), ok);
    if (!ok) return;
    repeat (3) @(negedge clk);
    rx_sent.push_back(8'h15);
    send_rx(8'h15);
    repeat (4) @(negedge clk);
    checks++;
    if (tx_log.size() != 1 || tx_log[0] !== 8'h06) begin
      errors++;
      $display("FAIL status_tx: %0d bytes first %h required 1 byte 06", tx_log.size(),
               (tx_log.size() > 0) ? tx_log[0] : 8'h00);
    end
    checks++;
    b = status_byte;
    if (b !== 8'h15 || rsp_log.size() != 1 || last_log.size() != 1 || !last_log[0] ||
        done_cnt != 1) begin
      errors++;
      $display("FAIL status_rsp: status=%h rsp=%0d done=%0d required 15/1/1", b,
               rsp_log.size(), done_cnt);
    end
  endtask

  task automatic test_random();
    logic [7:0]  cmd;
    logic [15:0] len;
    for (int t = 0; t < 14; t++) begin
      for (int i = 0; i < 256; i++) src_mem[i] = 8'($urandom);
      cmd = 8'($urandom_range(1, 6));
      len = (cmd == 8'h04) ? 16'($urandom_range(0, 100)) : 16'($urandom_range(0, 24));
      run_txn(cmd, 16'($urandom), len, $urandom_range(0, 2), rsp_len_of(cmd, len),
              "random");
    end
  endtask

  task automatic test_timeout();
    run_txn(8'h04, 16'($urandom), 16'd1, 0, 10, "timeout");
  endtask

  task automatic test_strays();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) send_rx(8'($urandom));
    repeat (2) @(negedge clk);
    checks++;
    if (stray_count !== 8'd3) begin
      errors++;
      $display("FAIL stray_count: %0d required 3", stray_count);
    end
    for (int i = 0; i < 260; i++) send_rx(8'($urandom));
    repeat (2) @(negedge clk);
    checks++;
    if (stray_count !== 8'hFF) begin
      errors++;
      $display("FAIL stray_saturate: %h required ff", stray_count);
    end
  endtask

  task automatic test_illegal();
    logic [7:0] ops [4];
    bit ok;
    ops[0] = 8'h09;
    ops[1] = 8'h00;
    ops[2] = 8'hFF;
    ops[3] = 8'($urandom_range(7, 255));
    for (int k = 0; k < 4; k++) begin
      bp_mode = 0;
      clear_logs();
      do_req(ops[k], 16'($urandom), 16'($urandom), ok);
      if (!ok) return;
      @(negedge clk);
      checks++;
      if (error !== 1'b1 || req_ready !== 1'b0 || tx_valid !== 1'b0) begin
        errors++;
        $display("FAIL illegal_err: op=%h error=%b req_ready=%b required 1/0", ops[k],
                 error, req_ready);
      end
      @(negedge clk);
      checks++;
      if (error !== 1'b0 || req_ready !== 1'b1 || tx_log.size() != 0 || done_cnt != 0) begin
        errors++;
        $display("FAIL illegal_recover: op=%h error=%b req_ready=%b tx=%0d required 0/1/0",
                 ops[k], error, req_ready, tx_log.size());
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n = 0;
    bp_mode = 0;
    for (int i = 0; i < 256; i++) src_mem[i] = 8'($urandom);
    clear_logs();
    do_req(8'h01, 16'($urandom), 16'd100, ok);
    if (!ok) return;
    while (!(tx_valid && addr_log.size() >= 10) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(tx_valid && addr_log.size() >= 10)) begin
      errors++;
      $display("FAIL reset_mid_reach: fetched %0d required at least 10", addr_log.size());
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0 || src_rd_en !== 1'b0 ||
        done !== 1'b0 || error !== 1'b0 || status_byte !== 8'h00 || stray_count !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid: txv=%b busy=%b rdy=%b status=%h stray=%h required all 0",
               tx_valid, busy, req_ready, status_byte, stray_count);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_release: rdy=%b busy=%b txv=%b required 1/0/0", req_ready,
               busy, tx_valid);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_cmd     = 8'h00;
    req_addr    = 16'h0000;
    req_len     = 16'h0000;
    src_rd_data = 8'h00;
    tx_ready    = 1'b1;
    rx_data     = 8'h00;
    rx_valid    = 1'b0;
    for (int i = 0; i < 256; i++) src_mem[i] = 8'($urandom);
    test_reset();
    test_write_ub();
    test_write_instr_bp();
    test_read_ub();
    test_status();
    test_random();
    test_timeout();
    test_strays();
    test_illegal();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_dma_host.md
Name: uart_dma_host

Overview:
- Byte-level command initiator for the board's UART DMA command protocol. It builds and transmits command frames (opcode, address, length, payload) and collects response bytes (UB read-back, status).
- Used on-chip to drive a second board or a loopback harness, and as the golden protocol master in system simulation.
- Connects to a uart_tx/uart_rx pair through a valid/ready byte interface.
- Sources payload from a byte-addressed source memory.

Parameters:
- RX_TIMEOUT, 2_000_000, cycles without an rx byte during a response before the transaction aborts (20 ms at 100 MHz).
- CHUNK_BYTES, 32, UB read-back block size in bytes; must be a power of two.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  command request
- req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready
- req_cmd  in  8  opcode: 01 write UB, 02 write weight, 03 write instr, 04 read UB, 05 execute, 06 status
- req_addr  in  16  target address, sent hi then lo
- req_len  in  16  byte length for 01/02/04; ignored otherwise
- src_rd_en  out  1  payload fetch strobe
- src_rd_addr  out  16  payload byte index, 0-based
- src_rd_data  in  8  payload byte, valid 1 cycle after src_rd_en
- tx_data  out  8  byte to uart_tx
- tx_valid  out  1  byte offered to uart_tx
- tx_ready  in  1  uart_tx can accept a byte
- rx_data  in  8  byte from uart_rx
- rx_valid  in  1  single-cycle strobe from uart_rx
- rsp_data  out  8  received response byte
- rsp_valid  out  1  1-cycle pulse per response byte
- rsp_last  out  1  high with the final rsp_valid of a transaction
- status_byte  out  8  last status received (opcode 06)
- busy  out  1  high whenever not in IDLE
- done  out  1  1-cycle pulse on successful completion
- error  out  1  1-cycle pulse on illegal opcode or rx timeout
- stray_count  out  8  saturating count of rx bytes received outside RECV

Behaviour:
- Reset: all outputs 0 (req_ready = 0 during reset), state IDLE, all counters 0. Reset mid-transaction drops tx_valid immediately; the partial frame is abandoned.
- Request capture: on acceptance, latch cmd/addr/len; req_ready falls the next cycle.
- Illegal opcode: no bytes sent, error pulses the cycle after acceptance, return to IDLE.
- Frame layout:
  - Header for 01/02/04: cmd, addr[15:8], addr[7:0], len[15:8], len[7:0].
  - Header for 03: cmd, addr[15:8], addr[7:0].
  - Header for 05/06: cmd only.
- Payload length: req_len bytes for 01/02 (0 means header only); exactly 4 bytes for 03; none otherwise.
- Response length:
  - 04: CHUNK_BYTES * max(1, ceil(len/CHUNK_BYTES)), computed in 17 bits, so len=0 gives 32 and len=FFFF gives 65536.
  - 06: 1 byte. Others: none.
- TX handshake: tx_data stable and tx_valid held until a tx_ready cycle. Byte is consumed on tx_valid && tx_ready. tx_valid may reassert the cycle after acceptance only with the next byte.
- States:
  - IDLE: waits for a request.
  - HDR: sends header bytes, indexed 0..hdr_len-1. After the last byte, go to FETCH if payload > 0, else RECV if response > 0, else DONE.
  - FETCH: src_rd_en=1, src_rd_addr=payload index. Next cycle go to DATA.
  - DATA: register src_rd_data into tx_data, assert tx_valid, wait for acceptance. Increment the index; go to FETCH if bytes remain, else RECV or DONE as above.
  - RECV: each rx_valid produces rsp_data=rx_data and rsp_valid=1 the next cycle; the timeout counter clears. For 06, also latch status_byte. When the final byte arrives, rsp_last=1 and go to DONE.
  - DONE: pulse done for 1 cycle, then IDLE.
- Timeout: counts only in RECV. When it reaches RX_TIMEOUT, error pulses, rsp_last is not asserted, return to IDLE; bytes already delivered remain valid.
- Stray bytes: rx_valid in any state other than RECV increments stray_count (saturating at FF); the byte is discarded.
- Counters: payload and response counters are 17 bits; no wrap within a transaction.

Test Plan:
- Write UB: req 01, addr 0x0012, len 3, src={AA,BB,CC}, tx_ready always 1 -> tx sequence 01 00 12 00 03 AA BB CC, no rx expected, done pulses once, busy falls with done.
- Write instr with backpressure: req 03, addr 0x0007, src={DE,AD,BE,EF}, tx_ready low 5 cycles after each acceptance -> tx sequence 01..: 03 00 07 DE AD BE EF; tx_data constant while tx_valid && !tx_ready; src_rd_addr 0..3.
- Read UB: req 04, addr 0x0000, len 40 -> tx sequence 04 00 00 00 28; 64 injected rx bytes appear on rsp in order; rsp_last on byte 64; done pulses.
- Status: req 06, rx responds 0x15 -> tx sequence 06 only; status_byte=0x15; one rsp_valid with rsp_last; done pulses.
- Timeout and strays: req 04 len 1 with only 10 rx bytes injected -> after RX_TIMEOUT idle cycles error pulses, no done, return to IDLE. Then 3 rx bytes in IDLE -> stray_count=3.
- Illegal and reset: req 0x09 -> no tx, error pulses, req_ready high 2 cycles later. Then start req 01 len 100 and assert rst_n low mid-payload -> tx_valid=0 and busy=0 immediately, outputs at reset values.
